base_vlat_pipe: RTL and testbench

Parametrised, depth-configurable pipeline register with valid/ready flow control, bubble collapsing, synchronous flush and an occupancy count. It is the next-generation replacement for the single-stage reset-value latch. It sits anywhere a datapath needs N cycles of registered delay with backpressure, for example command and response paths between DI units. Each stage holds one beat. A stage advances whenever the stage downstream of it is empty or is itself advancing.

---
 rtl/base_pkg.sv | 9 +
 rtl/base_vlat_pipe_if.sv | 21 ++
 rtl/base_vlat_pipe_stage.sv | 36 +++
 rtl/base_vlat_pipe.sv | 97 +++++++++
 tb/tb_base_vlat_pipe.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/base_pkg.sv
// Shared helpers for the base pipeline blocks.
package base_pkg;

  // Bits needed to count 0..depth valid stages.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 32'sd1);
  endfunction

endpackage

// File: rtl/base_vlat_pipe_if.sv
// Valid/ready beat interface for base_vlat_pipe, with flush and occupancy.
interface base_vlat_pipe_if
  import base_pkg::*;
#(
  parameter int width = 1,
  parameter int depth = 2
) ();
  localparam int cw = cnt_width(depth);

  logic             flush;
  logic             i_v;
  logic [width-1:0] i_d;
  logic             i_r;
  logic             o_v;
  logic [width-1:0] o_d;
  logic             o_r;
  logic [cw-1:0]    o_cnt;

  modport master (output flush, i_v, i_d, o_r, input i_r, o_v, o_d, o_cnt);
  modport slave  (input flush, i_v, i_d, o_r, output i_r, o_v, o_d, o_cnt);
endinterface

// File: rtl/base_vlat_pipe_stage.sv
// One pipeline stage: valid bit plus data register with load enable and flush.
module base_vlat_pipe_stage #(
  parameter int               width = 1,
  parameter logic [width-1:0] rstv  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             ld,
  input  logic             src_v,
  input  logic [width-1:0] src_d,
  output logic             v,
  output logic [width-1:0] d
);

  // Valid bit: cleared by flush, otherwise follows the source when advancing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v <= 1'b0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (ld) begin
      v <= src_v;
    end
  end

  // Data only captures real beats so idle cycles do not toggle the register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d <= rstv;
    end else if (ld && src_v) begin
      d <= src_d;
    end
  end

endmodule

// File: rtl/base_vlat_pipe.sv
// Depth-configurable valid/ready pipeline with bubble collapsing, flush and
// registered occupancy count.
module base_vlat_pipe
  import base_pkg::*;
#(
  parameter int               width = 1,
  parameter int               depth = 2,
  parameter logic [width-1:0] rstv  = '0
) (
  input logic             clk,
  input logic             reset_n,
  base_vlat_pipe_if.slave pif
);
  localparam int cw = cnt_width(depth);

  logic [depth-1:0] v_s;
  logic [depth-1:0] adv_s;
  logic [depth-1:0] nv_s;
  logic [depth-1:0] src_v_s;
  logic [width-1:0] d_s     [depth];
  logic [width-1:0] src_d_s [depth];
  logic [cw-1:0]    cnt_nxt_s;
  logic [cw-1:0]    cnt_r;

  // Ready chain: a stage advances unless it and everything below it is full
  // while the sink stalls.
  always_comb begin
    logic full_below;
    full_below = 1'b1;
    adv_s      = '0;
    for (int k = depth - 1; k >= 0; k--) begin
      full_below = full_below & v_s[k];
      adv_s[k]   = ~full_below | pif.o_r;
    end
  end

  for (genvar k = 0; k < depth; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_v_s[k] = pif.i_v;
      assign src_d_s[k] = pif.i_d;
    end else begin : g_body
      assign src_v_s[k] = v_s[k-1];
      assign src_d_s[k] = d_s[k-1];
    end

    base_vlat_pipe_stage #(
      .width (width),
      .rstv  (rstv)
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (pif.flush),
      .ld      (adv_s[k] & ~pif.flush),
      .src_v   (src_v_s[k]),
      .src_d   (src_d_s[k]),
      .v       (v_s[k]),
      .d       (d_s[k])
    );
  end

  // Next-state valids mirror the stage update so the count tracks each edge.
  always_comb begin
    nv_s = '0;
    for (int k = 0; k < depth; k++) begin
      if (pif.flush) begin
        nv_s[k] = 1'b0;
      end else if (adv_s[k]) begin
        nv_s[k] = src_v_s[k];
      end else begin
        nv_s[k] = v_s[k];
      end
    end
  end

  // Population count of next-state valids.
  always_comb begin
    cnt_nxt_s = '0;
    for (int k = 0; k < depth; k++) begin
      cnt_nxt_s = cnt_nxt_s + cw'(nv_s[k]);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign pif.i_r   = adv_s[0] & ~pif.flush & reset_n;
  assign pif.o_v   = v_s[depth-1];
  assign pif.o_d   = d_s[depth-1];
  assign pif.o_cnt = cnt_r;

endmodule

// File: tb/tb_base_vlat_pipe.sv
// Scoreboard bench for base_vlat_pipe (width 8, depth 3, rstv 8'hA5).
module tb_base_vlat_pipe;
  localparam int         W  = 8;
  localparam int         D  = 3;
  localparam logic [7:0] RV = 8'hA5;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  base_vlat_pipe_if #(.width(W), .depth(D)) pif ();

  base_vlat_pipe #(.width(W), .depth(D), .rstv(RV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pif     (pif)
  );

  int         n_pass    = 0;
  int         n_total   = 0;
  int         cyc       = 0;
  int         n_del     = 0;
  int         first_acc = -1;
  int         first_del = -1;
  bit         track     = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int         s_ir, s_cnt, s_ov;
  int         del0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: a transfer happens at the next edge whenever o_v & o_r.
  always @(negedge clk) begin
    if (reset_n && pif.o_v && pif.o_r) begin
      n_del++;
      if (track && first_del < 0) first_del = cyc;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", pif.o_d);
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat_data", int'(pif.o_d), int'(mon_exp));
      end
    end
  end

  // One cycle of stimulus; records accepted beats and samples status.
  task automatic step(input bit v, input logic [7:0] d, input bit ordy, input bit fl);
    pif.i_v   = v;
    pif.i_d   = d;
    pif.o_r   = ordy;
    pif.flush = fl;
    @(negedge clk);
    s_ir  = int'(pif.i_r);
    s_cnt = int'(pif.o_cnt);
    s_ov  = int'(pif.o_v);
    if (v && pif.i_r) begin
      exp_q.push_back(d);
      if (track && first_acc < 0) first_acc = cyc + 1;
    end
    if (fl) begin
      #1;
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    pif.i_v = 1'b0; pif.i_d = 8'h00; pif.o_r = 1'b0; pif.flush = 1'b0;

    // Reset values, asserted asynchronously before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    check("rst_o_v",   int'(pif.o_v),   0);
    check("rst_o_d",   int'(pif.o_d),   int'(RV));
    check("rst_o_cnt", int'(pif.o_cnt), 0);
    check("rst_i_r",   int'(pif.i_r),   0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_i_r", int'(pif.i_r), 1);
    @(posedge clk); #1;

    // Streaming 0x01..0x10 with o_r high.
    track = 1'b1;
    del0  = n_del;
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    track = 1'b0;
    check("stream_latency", first_del - first_acc, D - 1);
    check("stream_count", n_del - del0, 16);
    check("stream_drained", exp_q.size(), 0);

    // Backpressure: fill, then release o_r.
    step(1'b1, 8'h21, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h23, 1'b0, 1'b0);
    check("bp_ir_third", s_ir, 1);
    step(1'b1, 8'h24, 1'b0, 1'b0);
    check("bp_ir_full", s_ir, 0);
    check("bp_cnt_full", s_cnt, 3);
    step(1'b1, 8'h24, 1'b1, 1'b0);
    check("bp_ir_rise", s_ir, 1);
    step(1'b1, 8'h25, 1'b1, 1'b0);
    check("bp_cnt_swap", s_cnt, 3);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("bp_drained", exp_q.size(), 0);

    // Bubble collapse with the sink stalled.
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("bubble_cnt", s_cnt, 2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("bubble_packed", s_ov, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("bubble_drained", exp_q.size(), 0);

    // Flush with a full pipe and a pending input beat.
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b1, 1'b1);
    check("flush_i_r", s_ir, 0);
    check("flush_o_v_visible", s_ov, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("flush_cnt", s_cnt, 0);
    check("flush_o_v", s_ov, 0);
    step(1'b1, 8'h45, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("flush_drained", exp_q.size(), 0);

    // Asynchronous reset mid-stream.
    step(1'b1, 8'h51, 1'b0, 1'b0);
    step(1'b1, 8'h52, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("ar_cnt_before", s_cnt, 2);
    #3 reset_n = 1'b0;
    #1;
    check("ar_o_v",   int'(pif.o_v),   0);
    check("ar_o_cnt", int'(pif.o_cnt), 0);
    check("ar_i_r",   int'(pif.i_r),   0);
    check("ar_o_d",   int'(pif.o_d),   int'(RV));
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(1'b1, 8'h53, 1'b1, 1'b0);
    check("ar_empty_after", s_cnt, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("ar_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
